// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the core MEM stage (port C) and
// a debug/loader port (port D). One transaction is in flight at a time; its
// response returns a fixed LAT cycles after the grant. Port C normally wins,
// but once port D has lost STARVE_MAX slots in a row it is given the next one.
//
// Parameters
//   ADDR_W      byte address width
//   DATA_W      data width (byte mask width is DATA_W/8)
//   LAT         memory read latency in cycles, 1..4
//   STARVE_MAX  lost slots after which port D is forced through, 1..255
//
// Ports
//   clk, rst                  clock (rising edge) / async active-low reset
//   c_* / d_*  requests       req, we, addr, wdata, wmask per port
//   c_gnt / d_gnt             request accepted this cycle (combinational)
//   c_rvalid / d_rvalid       one-cycle completion pulse
//   c_rdata / d_rdata         read data on a read completion, else 0
//   c_stall                   pipeline freeze while a core access is pending
//   mem_en/we/addr/wdata/wmask memory command, zero unless mem_en is high
//   mem_rdata                 memory read data, valid LAT cycles after mem_en
//   busy                      a transaction is outstanding
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LAT        = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst,
   // core port
   input  logic                c_req,
   input  logic                c_we,
   input  logic [ADDR_W-1:0]   c_addr,
   input  logic [DATA_W-1:0]   c_wdata,
   input  logic [DATA_W/8-1:0] c_wmask,
   output logic                c_gnt,
   output logic                c_rvalid,
   output logic [DATA_W-1:0]   c_rdata,
   output logic                c_stall,
   // debug / loader port
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   // memory side
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   // status
   output logic                busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic       OWN_C      = 1'b0;
   localparam logic       OWN_D      = 1'b1;
   // Counter reload: the response is due when cnt reaches zero.
   localparam logic [1:0] CNT_LOAD   = 2'(LAT - 1);
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   state_t      state_r;
   logic [1:0]  cnt_r;
   logic        owner_r;
   logic        wr_r;       // in-flight transaction is a write (rdata forced to 0)
   logic [7:0]  starve_r;

   logic        slot_s;
   logic        resp_s;
   logic        d_force_s;
   logic        c_win_s;
   logic        d_win_s;

   // Arbitration slot detection and winner selection for the current cycle.
   always_comb begin
      slot_s = 1'b0;
      resp_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            slot_s = 1'b1;
            resp_s = 1'b0;
         end
         ST_WAIT: begin
            // The response cycle doubles as the next slot, giving LAT=1 full rate.
            slot_s = (cnt_r == 2'd0);
            resp_s = (cnt_r == 2'd0);
         end
         default: begin
            slot_s = 1'b0;
            resp_s = 1'b0;
         end
      endcase
      d_force_s = d_req & (starve_r == STARVE_LIM);
      // Grants are gated by rst so they drop the instant reset is asserted.
      c_win_s   = rst & slot_s & c_req & ~d_force_s;
      d_win_s   = rst & slot_s & d_req & ~c_win_s;
   end

   // Output decode: grants, memory command mux, responses and stall.
   always_comb begin
      c_gnt  = c_win_s;
      d_gnt  = d_win_s;
      mem_en = c_win_s | d_win_s;
      if (c_win_s) begin
         mem_we    = c_we;
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
         mem_wmask = c_wmask;
      end else if (d_win_s) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_wmask = d_wmask;
      end else begin
         mem_we    = 1'b0;
         mem_addr  = {ADDR_W{1'b0}};
         mem_wdata = {DATA_W{1'b0}};
         mem_wmask = {(DATA_W/8){1'b0}};
      end
      busy     = rst & (state_r == ST_WAIT);
      c_rvalid = rst & resp_s & (owner_r == OWN_C);
      d_rvalid = rst & resp_s & (owner_r == OWN_D);
      c_rdata  = (c_rvalid & ~wr_r) ? mem_rdata : {DATA_W{1'b0}};
      d_rdata  = (d_rvalid & ~wr_r) ? mem_rdata : {DATA_W{1'b0}};
      // Stall covers the request cycle and the wait, but not the completion cycle.
      c_stall  = rst & (c_req | ((owner_r == OWN_C) & busy & ~c_rvalid));
   end

   // Transaction FSM, latency counter, owner tracking and starvation counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 2'd0;
         owner_r  <= OWN_C;
         wr_r     <= 1'b0;
         starve_r <= 8'd0;
      end else begin
         if (c_win_s | d_win_s) begin
            state_r <= ST_WAIT;
            cnt_r   <= CNT_LOAD;
            owner_r <= d_win_s ? OWN_D : OWN_C;
            wr_r    <= d_win_s ? d_we : c_we;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 2'd0;
               end
               ST_WAIT: begin
                  if (cnt_r == 2'd0) begin
                     state_r <= ST_IDLE;
                     cnt_r   <= 2'd0;
                  end else begin
                     state_r <= ST_WAIT;
                     cnt_r   <= cnt_r - 2'd1;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 2'd0;
               end
            endcase
            owner_r <= owner_r;
            wr_r    <= wr_r;
         end

         // D loses a slot only when it was requesting and C took it.
         if (slot_s) begin
            if (d_win_s | ~d_req) begin
               starve_r <= 8'd0;
            end else if (c_win_s && (starve_r != STARVE_LIM)) begin
               starve_r <= starve_r + 8'd1;
            end else begin
               starve_r <= starve_r;
            end
         end else begin
            starve_r <= starve_r;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Two arbiter instances run side by side: instance 0 with LAT=1/STARVE_MAX=8,
// instance 1 with LAT=3/STARVE_MAX=3. Each port is fed from a transaction
// queue (entries carry an idle gap before they are presented). A timeline
// model (next free slot time, response due time, loss count, shadow memory)
// predicts every output of both instances every cycle; directed scenarios add
// explicit point checks on top.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [7:0]  gap;
   } txn_t;

   logic        clk;
   logic        rst;
   logic        mem_load;

   logic        c_req [2], d_req [2], c_we [2], d_we [2];
   logic [31:0] c_addr [2], d_addr [2], c_wdata [2], d_wdata [2];
   logic [3:0]  c_wmask [2], d_wmask [2];
   logic        c_gnt [2], d_gnt [2], c_rvalid [2], d_rvalid [2], c_stall [2];
   logic [31:0] c_rdata [2], d_rdata [2];
   logic        mem_en [2], mem_we [2], busy [2];
   logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
   logic [3:0]  mem_wmask [2];

   logic [31:0] phys [2][64];
   logic [31:0] pipe [2][4];

   int checks;
   int failures;
   int cyc;

   // transaction queues, k = 2*instance + (0 for C, 1 for D)
   txn_t qb [4][256];
   int   qh [4];
   int   qt [4];

   // reference model state
   int          free_at [2];
   int          resp_at [2];
   int          gnt_at [2];
   int          starve [2];
   logic        pend [2];
   logic        resp_d [2];
   logic [31:0] resp_data [2];
   logic        eg_c [2];
   logic        eg_d [2];
   logic [31:0] shadow [2][64];

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int smax_of(input int i);
      return (i == 0) ? 8 : 3;
   endfunction

   function automatic logic [31:0] init_word(input int i, input int a);
      if (a == 4) return 32'hDEADBEEF;
      return (32'(a) * 32'h0001_0003) ^ 32'h5A00_0000 ^ (32'(i) << 20);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] wm);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [159:0] vec(input logic cg, input logic dg, input logic crv,
                                        input logic drv, input logic cst, input logic men,
                                        input logic mwe, input logic bsy, input logic [3:0] mwm,
                                        input logic [31:0] crd, input logic [31:0] drd,
                                        input logic [31:0] ma, input logic [31:0] mwd);
      return {20'd0, cg, dg, crv, drv, cst, men, mwe, bsy, mwm, crd, drd, ma, mwd};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int GL = (g == 0) ? 1 : 3;
      localparam int GS = (g == 0) ? 8 : 3;
      dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(GL), .STARVE_MAX(GS)) u_dut (
         .clk(clk), .rst(rst),
         .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
         .c_wmask(c_wmask[g]), .c_gnt(c_gnt[g]), .c_rvalid(c_rvalid[g]),
         .c_rdata(c_rdata[g]), .c_stall(c_stall[g]),
         .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
         .d_wmask(d_wmask[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]),
         .d_rdata(d_rdata[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_wmask(mem_wmask[g]), .mem_rdata(mem_rdata[g]),
         .busy(busy[g])
      );
      assign mem_rdata[g] = pipe[g][GL-1];
   end

   always #5 clk = ~clk;

   // Memory model: read data delayed through a pipe, garbage when not valid.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int s = 3; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
         if (mem_en[i] && !mem_we[i]) pipe[i][0] <= phys[i][mem_addr[i][7:2]];
         else pipe[i][0] <= $urandom;
         if (mem_load) begin
            for (int a = 0; a < 64; a++) phys[i][a] <= init_word(i, a);
         end else if (mem_en[i] && mem_we[i]) begin
            phys[i][mem_addr[i][7:2]] <= merge(phys[i][mem_addr[i][7:2]],
                                               mem_wdata[i], mem_wmask[i]);
         end
      end
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm, input logic [7:0] gap);
      qb[k][qt[k] % 256] = {we, addr, wd, wm, gap};
      qt[k]++;
   endtask

   task automatic head_of(input int k, output logic rq, output txn_t t);
      rq = (qh[k] != qt[k]) && (qb[k][qh[k] % 256].gap == 8'd0);
      if (rq) t = qb[k][qh[k] % 256];
      else t = {1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 8'd0};
   endtask

   task automatic apply_inputs();
      txn_t t;
      logic rq;
      for (int i = 0; i < 2; i++) begin
         head_of(2*i, rq, t);
         c_req[i] = rq; c_we[i] = t.we; c_addr[i] = t.addr;
         c_wdata[i] = t.wdata; c_wmask[i] = t.wmask;
         head_of(2*i + 1, rq, t);
         d_req[i] = rq; d_we[i] = t.we; d_addr[i] = t.addr;
         d_wdata[i] = t.wdata; d_wmask[i] = t.wmask;
      end
   endtask

   task automatic adv_port(input int k, input logic g);
      if (g) qh[k]++;
      else if (qh[k] != qt[k] && qb[k][qh[k] % 256].gap != 8'd0)
         qb[k][qh[k] % 256].gap = qb[k][qh[k] % 256].gap - 8'd1;
   endtask

   task automatic model_check(input int i);
      logic gc, gd, slot, rvc, rvd, bsy, stall, men, mwe;
      logic [31:0] crd, drd, maddr, mwd;
      logic [3:0]  mwm;
      txn_t t;
      gc = 1'b0; gd = 1'b0; rvc = 1'b0; rvd = 1'b0; bsy = 1'b0; stall = 1'b0;
      men = 1'b0; mwe = 1'b0; crd = 32'd0; drd = 32'd0; maddr = 32'd0; mwd = 32'd0;
      mwm = 4'd0;
      t = '0;
      if (!rst) begin
         pend[i] = 1'b0; starve[i] = 0; free_at[i] = 0;
      end else begin
         slot  = (cyc >= free_at[i]);
         rvc   = pend[i] && (cyc == resp_at[i]) && !resp_d[i];
         rvd   = pend[i] && (cyc == resp_at[i]) && resp_d[i];
         bsy   = pend[i] && (cyc > gnt_at[i]) && (cyc <= resp_at[i]);
         stall = c_req[i] || (pend[i] && !resp_d[i] && bsy && !rvc);
         if (rvc) crd = resp_data[i];
         if (rvd) drd = resp_data[i];
         gc = slot && c_req[i] && !(d_req[i] && starve[i] == smax_of(i));
         gd = slot && d_req[i] && !gc;
         if (gc) t = {c_we[i], c_addr[i], c_wdata[i], c_wmask[i], 8'd0};
         if (gd) t = {d_we[i], d_addr[i], d_wdata[i], d_wmask[i], 8'd0};
         if (gc || gd) begin
            men = 1'b1; mwe = t.we; maddr = t.addr; mwd = t.wdata; mwm = t.wmask;
         end
         if (slot) begin
            if (gd || !d_req[i]) starve[i] = 0;
            else if (gc && starve[i] < smax_of(i)) starve[i] = starve[i] + 1;
         end
         if (pend[i] && cyc >= resp_at[i]) pend[i] = 1'b0;
         if (gc || gd) begin
            pend[i]    = 1'b1;
            gnt_at[i]  = cyc;
            resp_at[i] = cyc + lat_of(i);
            free_at[i] = cyc + lat_of(i);
            resp_d[i]  = gd;
            resp_data[i] = t.we ? 32'd0 : shadow[i][t.addr[7:2]];
            if (t.we) shadow[i][t.addr[7:2]] = merge(shadow[i][t.addr[7:2]], t.wdata, t.wmask);
         end
      end
      eg_c[i] = gc;
      eg_d[i] = gd;
      chk($sformatf("inst%0d_outputs", i),
          vec(c_gnt[i], d_gnt[i], c_rvalid[i], d_rvalid[i], c_stall[i], mem_en[i],
              mem_we[i], busy[i], mem_wmask[i], c_rdata[i], d_rdata[i], mem_addr[i],
              mem_wdata[i]),
          vec(gc, gd, rvc, rvd, stall, men, mwe, bsy, mwm, crd, drd, maddr, mwd));
   endtask

   task automatic eval();
      apply_inputs();
      @(negedge clk);
      model_check(0);
      model_check(1);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         adv_port(2*i, eg_c[i]);
         adv_port(2*i + 1, eg_d[i]);
      end
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         eval();
         next();
      end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; mem_load = 1'b1;
      checks = 0; failures = 0; cyc = 0;
      for (int k = 0; k < 4; k++) begin qh[k] = 0; qt[k] = 0; end
      for (int i = 0; i < 2; i++) begin
         free_at[i] = 0; resp_at[i] = 0; gnt_at[i] = 0; starve[i] = 0;
         pend[i] = 1'b0; resp_d[i] = 1'b0; resp_data[i] = 32'd0;
         eg_c[i] = 1'b0; eg_d[i] = 1'b0;
         for (int a = 0; a < 64; a++) shadow[i][a] = init_word(i, a);
      end
      #1 rst = 1'b0;

      // reset state, with a request already waiting on port C of instance 0
      push(0, 1'b0, 32'h10, 32'd0, 4'hF, 8'd0);
      eval();
      chk("rst_c_gnt", c_gnt[0], 1'b0);
      chk("rst_c_stall", c_stall[0], 1'b0);
      chk("rst_mem_en", mem_en[0], 1'b0);
      next();
      run(2);
      mem_load = 1'b0;
      rst = 1'b1;

      // core read, LAT=1 (request already held since reset)
      eval();
      chk("t1_c_gnt", c_gnt[0], 1'b1);
      chk("t1_mem_en", mem_en[0], 1'b1);
      chk("t1_mem_addr", mem_addr[0], 32'h10);
      chk("t1_stall_c0", c_stall[0], 1'b1);
      next();
      eval();
      chk("t1_c_rvalid", c_rvalid[0], 1'b1);
      chk("t1_c_rdata", c_rdata[0], 32'hDEADBEEF);
      chk("t1_stall_c1", c_stall[0], 1'b0);
      next();
      run(2);

      // simultaneous requests, LAT=1
      push(0, 1'b0, 32'h20, 32'd0, 4'hF, 8'd0);
      push(1, 1'b0, 32'h24, 32'd0, 4'hF, 8'd0);
      eval();
      chk("t2_c_gnt0", c_gnt[0], 1'b1);
      chk("t2_d_gnt0", d_gnt[0], 1'b0);
      next();
      eval();
      chk("t2_d_gnt1", d_gnt[0], 1'b1);
      chk("t2_c_rvalid1", c_rvalid[0], 1'b1);
      next();
      eval();
      chk("t2_d_rvalid2", d_rvalid[0], 1'b1);
      chk("t2_d_rdata2", d_rdata[0], init_word(0, 9));
      next();
      run(2);

      // starvation, LAT=1, STARVE_MAX=8
      for (int j = 0; j < 12; j++) push(0, 1'b0, 32'h40 + 32'(4*j), 32'd0, 4'hF, 8'd0);
      push(1, 1'b0, 32'h80, 32'd0, 4'hF, 8'd0);
      for (int s = 0; s < 9; s++) begin
         eval();
         if (s < 8) chk($sformatf("t3_c_slot%0d", s), c_gnt[0], 1'b1);
         else chk("t3_d_slot8", d_gnt[0], 1'b1);
         next();
      end
      eval();
      chk("t3_c_after_d", c_gnt[0], 1'b1);
      next();
      run(6);

      // back-to-back core writes, LAT=3
      for (int j = 0; j < 3; j++) push(2, 1'b1, 32'h60 + 32'(4*j), $urandom, 4'hF, 8'd0);
      for (int s = 0; s < 10; s++) begin
         eval();
         chk($sformatf("t4_c_gnt%0d", s), c_gnt[1], (s == 0 || s == 3 || s == 6));
         chk($sformatf("t4_mem_en%0d", s), mem_en[1], (s == 0 || s == 3 || s == 6));
         chk($sformatf("t4_rvalid%0d", s), c_rvalid[1], (s == 3 || s == 6 || s == 9));
         chk($sformatf("t4_busy%0d", s), busy[1], (s >= 1));
         if (s == 3 || s == 6 || s == 9) chk($sformatf("t4_rdata%0d", s), c_rdata[1], 32'd0);
         next();
      end
      run(2);

      // debug partial write, LAT=3, then read it back
      push(3, 1'b1, 32'h1C, 32'h0000ABCD, 4'b0011, 8'd0);
      eval();
      chk("t5_d_gnt", d_gnt[1], 1'b1);
      chk("t5_mem_we", mem_we[1], 1'b1);
      chk("t5_mem_wmask", mem_wmask[1], 4'b0011);
      chk("t5_mem_wdata", mem_wdata[1], 32'h0000ABCD);
      next();
      run(2);
      eval();
      chk("t5_d_rvalid", d_rvalid[1], 1'b1);
      chk("t5_d_rdata", d_rdata[1], 32'd0);
      next();
      push(3, 1'b0, 32'h1C, 32'd0, 4'hF, 8'd0);
      run(6);

      // reset mid-transaction, LAT=3
      push(2, 1'b0, 32'h30, 32'd0, 4'hF, 8'd0);
      eval();
      chk("t6_c_gnt", c_gnt[1], 1'b1);
      next();
      rst = 1'b0;
      eval();
      chk("t6_busy_drop", busy[1], 1'b0);
      chk("t6_stall_drop", c_stall[1], 1'b0);
      next();
      push(2, 1'b0, 32'h34, 32'd0, 4'hF, 8'd0);
      eval();
      chk("t6_rst_no_gnt", c_gnt[1], 1'b0);
      chk("t6_rst_no_en", mem_en[1], 1'b0);
      next();
      rst = 1'b1;
      for (int s = 3; s < 7; s++) begin
         eval();
         if (s == 3) chk("t6_regrant", c_gnt[1], 1'b1);
         chk($sformatf("t6_rvalid%0d", s), c_rvalid[1], (s == 6));
         if (s == 6) chk("t6_rdata", c_rdata[1], shadow[1][13]);
         next();
      end
      run(2);

      // randomized traffic on both instances, with one reset in the middle
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < 4; k++) begin
            if (qh[k] == qt[k] && $urandom_range(0, 3) != 0)
               push(k, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                    $urandom, 4'($urandom), 8'($urandom_range(0, 2)));
         end
         if (n == 300) rst = 1'b0;
         if (n == 302) rst = 1'b1;
         eval();
         next();
      end
      run(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the core's MEM stage (port C) and a debug/loader port (port D), so test programs and memory images can be loaded and inspected while the pipeline runs. It sits between the datapath and the data memory. It issues one transaction at a time to the memory and returns each response after a fixed latency. It drives a stall to the pipeline while a core access is pending, and it guarantees the debug port bounded waiting time.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (byte mask width = DATA_W/8)
- LAT, 1, memory read latency in cycles, legal 1..4
- STARVE_MAX, 8, number of lost arbitration slots after which port D wins, legal 1..255
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- c_req / d_req  input  1  request valid
- c_we / d_we  input  1  1 = write, 0 = read
- c_addr / d_addr  input  ADDR_W  byte address
- c_wdata / d_wdata  input  DATA_W  write data
- c_wmask / d_wmask  input  DATA_W/8  byte enables
- c_gnt / d_gnt  output  1  request accepted this cycle
- c_rvalid / d_rvalid  output  1  completion pulse; carries read data for reads
- c_rdata / d_rdata  output  DATA_W  read data, 0 for writes and when rvalid is low
- c_stall  output  1  freeze the pipeline
- mem_en, mem_we  output  1  memory access strobe and write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_wmask  output  DATA_W/8  memory byte mask
- mem_rdata  input  DATA_W  valid exactly LAT cycles after the mem_en cycle
- busy  output  1  transaction outstanding

## Operation
- States: IDLE and WAIT. A 2-bit down-counter `cnt` and an owner bit (C or D) hold the in-flight transaction.
- Arbitration slot: any cycle where the state is IDLE, or the state is WAIT with cnt==0. At most one grant per slot.
- Winner selection:
  - Port C wins if c_req is high, unless d_req is high and starve==STARVE_MAX; in that case D wins.
  - Otherwise D wins if d_req is high.
- On a grant:
  - Assert the winner's gnt and mem_en.
  - Drive the mem_* signals from the winner's fields. This is combinational, in the same cycle.
  - Latch the owner and set cnt=LAT-1.
  - Next state is WAIT.
- WAIT: cnt decrements each cycle. When cnt==0, the owner's rvalid is asserted. The owner's rdata = mem_rdata for reads, 0 for writes. If there is no new grant in that slot, the next state is IDLE.
- Starvation counter `starve` (8-bit, saturating at STARVE_MAX):
  - Increments in each slot where d_req is high and C is granted.
  - Clears on a D grant, or in any slot where d_req is low.
- c_stall = c_req | (owner==C & busy & ~c_rvalid).
- Requester contract:
  - req and its fields are held stable until gnt.
  - In the cycle after gnt, req describes a new transaction or is low.
  - The arbiter never reorders accesses within a port.
- No gnt, mem_en or rvalid is ever asserted for a port whose req was low.
- Reset (rst low), which takes effect immediately:
  - State is IDLE, cnt=0, starve=0.
  - All outputs are 0, including the combinational gnt and mem_en.
  - An in-flight transaction is dropped: no rvalid is produced for it.

## Timing
- Grant latency: 0 cycles when a slot is available, since gnt is combinational from req in a slot.
- Response: rvalid comes exactly LAT cycles after the gnt cycle, as a one-cycle pulse.
- Throughput: one transaction per LAT cycles. With LAT=1 the arbiter sustains one access per cycle, because the response cycle is also a slot.
- mem_en is asserted only in grant cycles. The mem_* outputs are 0 when mem_en is low.
- busy is high from the cycle after gnt through the rvalid cycle.
- Simultaneous requests with starve<STARVE_MAX: C is granted and D waits.
- For a core access with LAT=1, c_stall is high in the grant cycle and low in the rvalid cycle.

## Test plan
- Core read, LAT=1. Drive c_req, addr 0x10, at cycle 0; memory returns 0xDEADBEEF.
  - c_gnt and mem_en with mem_addr=0x10 at cycle 0.
  - c_rvalid with c_rdata=0xDEADBEEF at cycle 1.
  - c_stall is 1 at cycle 0 and 0 at cycle 1.
- Simultaneous requests, LAT=1. c_req and d_req both rise at cycle 0, and c_req drops after its gnt.
  - c_gnt at cycle 0, d_gnt at cycle 1.
  - c_rvalid at cycle 1, d_rvalid at cycle 2.
- Starvation, LAT=1, STARVE_MAX=8. c_req is high every cycle and d_req is held high.
  - C is granted in 8 consecutive slots, then d_gnt in the 9th slot.
  - starve returns to 0, and C is granted again in the next slot.
- Back-to-back core writes, LAT=3.
  - c_gnt at cycles 0, 3 and 6; c_rvalid at cycles 3, 6 and 9 with c_rdata=0.
  - mem_en is high only at cycles 0, 3 and 6; busy is continuously high from cycle 1 to cycle 9.
- Debug partial write. d_we=1, d_addr=0x1C, d_wmask=4'b0011, d_wdata=0x0000ABCD.
  - mem_we=1, mem_wmask=0011 and mem_wdata=0x0000ABCD in the grant cycle.
  - d_rvalid after LAT cycles, with d_rdata=0.
- Reset mid-transaction, LAT=3. Pull rst low one cycle after a core read grant.
  - All outputs drop to 0 immediately, and c_rvalid is never asserted.
  - After rst returns high, a new c_req is granted in its first cycle and completes normally.
